// File: rtl/memory_access.sv
// Memory-access stage of the in-order core: issues one outstanding data-memory
// request at a time, extends load data and latches results for writeback.
package memory_access_pkg;
  typedef enum logic [2:0] {
    LS_B  = 3'd0,
    LS_H  = 3'd1,
    LS_W  = 3'd2,
    LS_D  = 3'd3,
    LS_BU = 3'd4,
    LS_HU = 3'd5,
    LS_WU = 3'd6
  } load_store_variant_e;
endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [4:0]        in_rd,
  input  logic [63:0]       in_result,
  input  logic              in_write_to_rd,
  input  logic              in_is_branch,
  input  logic [63:0]       in_store_data,
  input  logic              in_is_mem,
  input  logic              in_is_write,
  input  logic              in_final,
  input  load_store_variant_e in_ls_variant,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  input  logic              stall_in,
  output logic              stall_out,
  output logic [4:0]        rd_q,
  output logic [63:0]       wb_data_q,
  output logic              write_to_rd_q,
  output logic              branch_taken_q,
  output logic              valid_q,
  output logic              final_q,
  output logic              misalign_q
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e state, state_next;

  logic [2:0]  offset;
  logic        misalign;
  logic        mem_op;
  logic        start;
  logic [63:0] mem_result;
  logic [63:0] hold_data_p1;

  logic retire_alu;
  logic retire_mem;
  logic retire_buf;
  logic capture;
  logic bubble;

  function automatic logic [3:0] access_size(input load_store_variant_e v);
    case (v)
      LS_B, LS_BU: access_size = 4'd1;
      LS_H, LS_HU: access_size = 4'd2;
      LS_W, LS_WU: access_size = 4'd4;
      default:     access_size = 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] byte_strobe(input load_store_variant_e v, input logic [2:0] off);
    case (v)
      LS_B, LS_BU: byte_strobe = 8'h01 << off;
      LS_H, LS_HU: byte_strobe = 8'h03 << off;
      LS_W, LS_WU: byte_strobe = 8'h0F << off;
      default:     byte_strobe = 8'hFF;
    endcase
  endfunction

  // Align the addressed bytes to bit 0, then sign- or zero-extend to 64 bits.
  function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [2:0] off,
                                              input load_store_variant_e v);
    logic [63:0]        s;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] r;
    s = raw >> {off, 3'b000};
    b = s[7:0];
    h = s[15:0];
    w = s[31:0];
    case (v)
      LS_B:    r = b;
      LS_H:    r = h;
      LS_W:    r = w;
      LS_BU:   r = {56'd0, s[7:0]};
      LS_HU:   r = {48'd0, s[15:0]};
      LS_WU:   r = {32'd0, s[31:0]};
      default: r = s;
    endcase
    load_extend = r;
  endfunction

  assign offset    = in_result[2:0];
  assign misalign  = ({1'b0, offset} + access_size(in_ls_variant)) > 4'd8;
  assign mem_op    = in_valid & in_is_mem;
  assign start     = mem_op & ~misalign & ~stall_in;

  assign mem_addr  = {in_result[ADDR_W-1:3], 3'b000};
  assign mem_we    = in_is_write;
  assign mem_wdata = in_store_data << {offset, 3'b000};
  assign mem_wstrb = byte_strobe(in_ls_variant, offset);

  // A store retires with its address as writeback data; a load with extended data.
  assign mem_result = in_is_write ? in_result : load_extend(mem_rdata, offset, in_ls_variant);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = mem_req_ready ? WAIT : REQ;
      REQ:  if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_rvalid) state_next = stall_in ? HOLD : IDLE;
      HOLD: if (!stall_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // While an access is in flight, writeback sees bubbles unless it is itself stalled.
  always_comb begin
    mem_req_valid = 1'b0;
    stall_out     = 1'b0;
    retire_alu    = 1'b0;
    retire_mem    = 1'b0;
    retire_buf    = 1'b0;
    capture       = 1'b0;
    bubble        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mem_req_valid = 1'b1;
          stall_out     = 1'b1;
          bubble        = 1'b1;
        end else begin
          stall_out  = stall_in;
          retire_alu = ~stall_in;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        stall_out     = 1'b1;
        bubble        = ~stall_in;
      end
      WAIT: begin
        if (mem_rvalid && !stall_in) begin
          retire_mem = 1'b1;
        end else begin
          stall_out = 1'b1;
          bubble    = ~stall_in & ~mem_rvalid;
          capture   = mem_rvalid & stall_in;
        end
      end
      HOLD: begin
        if (!stall_in) retire_buf = 1'b1;
        else           stall_out  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (capture) hold_data_p1 <= mem_result;
  end

  // Stage boundary: writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      rd_q           <= 5'd0;
      wb_data_q      <= 64'd0;
      write_to_rd_q  <= 1'b0;
      branch_taken_q <= 1'b0;
      final_q        <= 1'b0;
      misalign_q     <= 1'b0;
    end else if (retire_alu) begin
      valid_q        <= in_valid;
      rd_q           <= in_rd;
      wb_data_q      <= in_result;
      write_to_rd_q  <= in_valid & in_write_to_rd & ~(in_is_mem & (in_is_write | misalign));
      branch_taken_q <= in_valid & in_is_branch;
      final_q        <= in_valid & in_final;
      misalign_q     <= misalign_q | (mem_op & misalign);
    end else if (retire_mem || retire_buf) begin
      valid_q        <= 1'b1;
      rd_q           <= in_rd;
      wb_data_q      <= retire_buf ? hold_data_p1 : mem_result;
      write_to_rd_q  <= in_write_to_rd & ~in_is_write;
      branch_taken_q <= in_is_branch;
      final_q        <= in_final;
    end else if (bubble) begin
      valid_q        <= 1'b0;
    end
  end

endmodule
